// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencer for one radix-2 single-path delay-feedback stage.
// The first half-frame of samples is written into a FIFO (FILL). The second
// half-frame is paired with the FIFO contents: each accepted sample reads x1
// while x2 is registered, so the pair is valid one cycle after the read.
// The optional error flags are built only when SDF_CTRL_ERR_EN is defined;
// otherwise err_ovf/err_unf are tied to 0 and fifo_full/fifo_empty are ignored.
module sdf_stage_ctrl #(
  parameter int unsigned HALF_LOG2     = 10,
  parameter int unsigned TF_ADDR_LEN   = 10,
  parameter int unsigned TF_SHIFT      = 0,
  parameter int unsigned FRAME_CNT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in_valid,
  input  logic                     flush,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic                     fifo_wr_en,
  output logic                     fifo_rd_en,
  output logic                     fifo_clr,
  output logic                     pair_valid,
  output logic [TF_ADDR_LEN-1:0]   tf_addr,
  output logic                     frame_done,
  output logic [FRAME_CNT_LEN-1:0] frame_cnt,
  output logic                     err_ovf,
  output logic                     err_unf
);

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [HALF_LOG2-1:0]   idx;
  logic [HALF_LOG2-1:0]   idx_next;
  logic                   idx_last;
  logic                   accept;
  logic [TF_ADDR_LEN-1:0] tf_next;

  assign idx_last = &idx;
  assign accept   = data_in_valid & ~flush;
  // Widen (or truncate) first, then shift: bits pushed past TF_ADDR_LEN drop out.
  assign tf_next  = TF_ADDR_LEN'(idx) << TF_SHIFT;

  // State and half-frame index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next state: flush wins, otherwise advance on every accepted sample and
  // toggle FILL/PAIR when the last sample of a half-frame is taken.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (flush) begin
      state_next = FILL;
      idx_next   = '0;
    end else if (data_in_valid) begin
      if (idx_last) begin
        idx_next   = '0;
        state_next = (state == FILL) ? PAIR : FILL;
      end else begin
        idx_next = idx + HALF_LOG2'(1);
      end
    end
  end

  // FIFO enables, aligned with the sample presented this cycle.
  always_comb begin
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      FILL:    fifo_wr_en = accept;
      PAIR:    fifo_rd_en = accept;
      default: begin
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
      end
    endcase
  end

  // Pair strobe, twiddle address and frame bookkeeping, one cycle after the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_clr   <= 1'b0;
      pair_valid <= 1'b0;
      tf_addr    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      fifo_clr   <= flush;
      pair_valid <= fifo_rd_en;
      frame_done <= fifo_rd_en & idx_last;
      if (fifo_rd_en) begin
        tf_addr <= tf_next;
      end
      if (fifo_rd_en && idx_last) begin
        frame_cnt <= frame_cnt + FRAME_CNT_LEN'(1);
      end
    end
  end

`ifdef SDF_CTRL_ERR_EN
  // Sticky diagnostics: the enable is still issued on the offending cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (fifo_full && fifo_wr_en) begin
        err_ovf <= 1'b1;
      end
      if (fifo_empty && fifo_rd_en) begin
        err_unf <= 1'b1;
      end
    end
  end
`else
  logic unused_fifo_flags;

  assign unused_fifo_flags = fifo_full ^ fifo_empty;
  assign err_ovf           = 1'b0;
  assign err_unf           = 1'b0;
`endif

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Synchronous sequencer for one radix-2 single-path delay stage: one half-frame FIFO plus a one-cycle input register that pair x1 (delayed) with x2 (current).
- Replaces edge-triggered enable generation with a counter-driven FSM.
- Drives FIFO write/read enables and the pair-valid strobe, and supplies the twiddle address aligned to each x1/x2 pair.
- Sits between the upstream sample source and the FIFO/butterfly of the same stage; one instance per stage.

Parameters:
- HALF_LOG2, 10: log2 of half-frame length; HALF = 2^HALF_LOG2 samples are buffered before pairing.
- TF_ADDR_LEN, 10: twiddle ROM address width (2^TF_ADDR_LEN = tf_num).
- TF_SHIFT, 0: left shift applied to the pair index to form tf_addr (stage stride). tf_addr = (idx << TF_SHIFT) truncated to TF_ADDR_LEN.
- FRAME_CNT_LEN, 16: width of the completed-frame counter.

Ports:
- clk, input, 1: stage clock.
- rst, input, 1: asynchronous, active-high reset.
- data_in_valid, input, 1: upstream sample valid; a sample is presented on every cycle this is high.
- flush, input, 1: synchronous abort of the current frame.
- fifo_full, input, 1: FIFO full flag.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_wr_en, output, 1: FIFO write enable; combinational, aligned with data_in.
- fifo_rd_en, output, 1: FIFO read enable; combinational.
- fifo_clr, output, 1: registered one-cycle FIFO clear pulse.
- pair_valid, output, 1: registered; x1 (FIFO dout) and x2 (registered input) are valid this cycle.
- tf_addr, output, TF_ADDR_LEN: registered twiddle address, aligned with pair_valid.
- frame_done, output, 1: registered one-cycle pulse coinciding with the last pair_valid of a frame.
- frame_cnt, output, FRAME_CNT_LEN: completed frames, wraps.
- err_ovf, output, 1: sticky; FIFO full seen before the fill completed.
- err_unf, output, 1: sticky; read issued while FIFO empty.

Behaviour:
- Reset values:
  - State FILL, idx = 0.
  - All outputs 0, including tf_addr, frame_cnt and both error flags.
- FSM states are FILL and PAIR. idx is a HALF_LOG2-bit counter that advances only on data_in_valid.
- FILL:
  - fifo_wr_en = data_in_valid; fifo_rd_en = 0.
  - On a valid with idx = HALF-1: idx goes to 0 and the state goes to PAIR.
- PAIR:
  - fifo_rd_en = data_in_valid; fifo_wr_en = 0.
  - Next cycle: pair_valid = 1 and tf_addr = (idx_at_read << TF_SHIFT).
  - On a valid with idx = HALF-1: idx goes to 0, the state goes to FILL, frame_done pulses with the final pair_valid, and frame_cnt increments in the same cycle.
- Latency:
  - x1/x2 pair: exactly 1 cycle from the read-side valid.
  - First pair of a frame: HALF valid input cycles plus 1.
- Gaps: data_in_valid low stalls the state and idx. pair_valid is low on the cycle after a gap cycle.
- Back-to-back frames: a valid arriving in the cycle after the PAIR to FILL transition is written as sample 0 of the next frame. No bubble is required.
- flush (takes priority over data_in_valid):
  - Next state is FILL, idx = 0.
  - fifo_clr = 1 on the next cycle.
  - Both enables are forced to 0 in the flush cycle.
  - pair_valid/frame_done are 0 on the next cycle.
  - frame_cnt and the error flags are unchanged.
- Reset mid-frame: immediate return to reset values. No FIFO clear is issued; the FIFO shares rst.
- Error flags (sticky until rst only):
  - err_ovf sets if fifo_full = 1 while fifo_wr_en = 1.
  - err_unf sets if fifo_empty = 1 while fifo_rd_en = 1.
  - On the offending cycle the enable is still issued; the flags are diagnostic only.
- frame_cnt wraps from 2^FRAME_CNT_LEN-1 to 0.

Optional Feature:
- Macro: SDF_CTRL_ERR_EN.
- Defined: err_ovf/err_unf logic as specified above.
- Undefined: both ports are tied to constant 0 and fifo_full/fifo_empty are unused. All other behaviour is identical.

Test Plan:
- HALF_LOG2=2, 8 continuous valids after reset:
  - fifo_wr_en high on cycles 0-3, fifo_rd_en high on cycles 4-7.
  - pair_valid high on cycles 5-8, tf_addr = 0,1,2,3.
  - frame_done on cycle 8; frame_cnt = 1.
- Same setup with TF_SHIFT=2: tf_addr = 0,4,8,12 on the four pair_valid cycles.
- Valid low on input samples 2 and 5 of a frame: idx holds; pair_valid has a matching 1-cycle hole; frame_done appears after 8 accepted samples.
- flush asserted on the 3rd FILL sample:
  - No write that cycle; fifo_clr pulses the next cycle.
  - The next 4 valids are all FILL writes.
  - frame_cnt is unchanged.
- 3 back-to-back frames of 8 valids: frame_cnt = 3, no idle cycle between frames, 12 pair_valid pulses total.
- With SDF_CTRL_ERR_EN: force fifo_full=1 during the 2nd FILL write gives err_ovf=1, held after the frame completes. Force fifo_empty=1 during a PAIR read gives err_unf=1. Without the macro both stay 0.
